// File: rtl/fxu_pkg.sv
// fxu_pkg: shared FXU opcodes, widths and reservation-station entry types
package fxu_pkg;
  localparam int TAG_W = 4;
  localparam int DATA_W = 16;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd4;
  localparam logic [3:0] OP_MOVL = 4'd5;
  localparam logic [3:0] OP_MOVH = 4'd6;
  typedef struct packed {
    logic rdy;
    logic [TAG_W-1:0] tag;
    logic [DATA_W-1:0] value;
  } operand_t;
  typedef struct packed {
    logic valid;
    logic [3:0] opcode;
    logic [TAG_W-1:0] rob_index;
    logic [8:0] imm;
    operand_t t;
    operand_t a;
    operand_t b;
  } rs_entry_t;
endpackage

// File: rtl/fxu_rs_if.sv
// fxu_rs_if: dispatch, result-broadcast and issue signals of the FXU reservation station
interface fxu_rs_if;
  import fxu_pkg::*;
  logic flush;
  logic disp_valid, disp_ready;
  logic [3:0] disp_opcode;
  logic [TAG_W-1:0] disp_rob_index;
  logic [8:0] disp_imm;
  logic disp_t_rdy, disp_a_rdy, disp_b_rdy;
  logic [TAG_W-1:0] disp_t_tag, disp_a_tag, disp_b_tag;
  logic [DATA_W-1:0] disp_t_val, disp_a_val, disp_b_val;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_rob_index;
  logic [DATA_W-1:0] cdb_value;
  logic iss_valid;
  logic [3:0] iss_opcode;
  logic [TAG_W-1:0] iss_rob_index;
  logic [DATA_W-1:0] iss_vt, iss_va, iss_vb;
  logic [8:0] iss_imm;
  modport master (
    output flush, disp_valid, disp_opcode, disp_rob_index, disp_imm,
           disp_t_rdy, disp_a_rdy, disp_b_rdy, disp_t_tag, disp_a_tag, disp_b_tag,
           disp_t_val, disp_a_val, disp_b_val, cdb_valid, cdb_rob_index, cdb_value,
    input  disp_ready, iss_valid, iss_opcode, iss_rob_index, iss_vt, iss_va, iss_vb, iss_imm
  );
  modport slave (
    input  flush, disp_valid, disp_opcode, disp_rob_index, disp_imm,
           disp_t_rdy, disp_a_rdy, disp_b_rdy, disp_t_tag, disp_a_tag, disp_b_tag,
           disp_t_val, disp_a_val, disp_b_val, cdb_valid, cdb_rob_index, cdb_value,
    output disp_ready, iss_valid, iss_opcode, iss_rob_index, iss_vt, iss_va, iss_vb, iss_imm
  );
endinterface

// File: rtl/rs_operand_capture.sv
// rs_operand_capture: next value of one operand after snooping the result broadcast
module rs_operand_capture import fxu_pkg::*; (
  input  operand_t cur,
  input  logic cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob_index,
  input  logic [DATA_W-1:0] cdb_value,
  output operand_t nxt
);
  logic hit;
  assign hit = !cur.rdy && cdb_valid && cur.tag == cdb_rob_index;
  assign nxt = {cur.rdy | hit, cur.tag, hit ? cdb_value : cur.value};
endmodule

// File: rtl/fxu_rs.sv
// fxu_rs: collapsing reservation station issuing the oldest ready instruction to the FXU
module fxu_rs import fxu_pkg::*; #(
  parameter int NUM_ENTRIES = 4
) (
  input logic clk,
  input logic reset,
  fxu_rs_if.slave bus
);
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  rs_entry_t q [NUM_ENTRIES];
  rs_entry_t q_next [NUM_ENTRIES];
  rs_entry_t woke [NUM_ENTRIES+1];
  rs_entry_t disp_entry;
  operand_t dt, da, db;
  logic [CW-1:0] count, fill;
  logic [NUM_ENTRIES-1:0] ready, shift;
  logic acc;
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
    operand_t t, a, b;
    rs_operand_capture u_t (.cur(q[i].t), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(t));
    rs_operand_capture u_a (.cur(q[i].a), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(a));
    rs_operand_capture u_b (.cur(q[i].b), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(b));
    assign woke[i] = {q[i].valid, q[i].opcode, q[i].rob_index, q[i].imm, t, a, b};
    assign ready[i] = q[i].valid && q[i].t.rdy && q[i].a.rdy && q[i].b.rdy;
  end
  assign woke[NUM_ENTRIES] = '0;
  rs_operand_capture u_dt (.cur({bus.disp_t_rdy, bus.disp_t_tag, bus.disp_t_val}), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(dt));
  rs_operand_capture u_da (.cur({bus.disp_a_rdy, bus.disp_a_tag, bus.disp_a_val}), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(da));
  rs_operand_capture u_db (.cur({bus.disp_b_rdy, bus.disp_b_tag, bus.disp_b_val}), .cdb_valid(bus.cdb_valid), .cdb_rob_index(bus.cdb_rob_index), .cdb_value(bus.cdb_value), .nxt(db));
  assign disp_entry = {1'b1, bus.disp_opcode, bus.disp_rob_index, bus.disp_imm, dt, da, db};
  assign bus.disp_ready = count < CW'(NUM_ENTRIES);
  assign bus.iss_valid = |ready;
  assign acc = bus.disp_valid && bus.disp_ready;
  assign fill = count - CW'(bus.iss_valid);
  // every slot at or above the issued one moves down by one
  always_comb begin
    shift = '0;
    shift[0] = ready[0];
    for (int k = 1; k < NUM_ENTRIES; k++) shift[k] = shift[k-1] | ready[k];
  end
  always_comb begin
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      q_next[k] = shift[k] ? woke[k+1] : woke[k];
      if (acc && fill == CW'(k)) q_next[k] = disp_entry;
    end
  end
  always_comb begin
    bus.iss_opcode = '0;
    bus.iss_rob_index = '0;
    bus.iss_imm = '0;
    bus.iss_vt = '0;
    bus.iss_va = '0;
    bus.iss_vb = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (ready[k]) begin
        bus.iss_opcode = q[k].opcode;
        bus.iss_rob_index = q[k].rob_index;
        bus.iss_imm = q[k].imm;
        bus.iss_vt = q[k].t.value;
        bus.iss_va = q[k].a.value;
        bus.iss_vb = q[k].b.value;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      count <= '0;
      for (int k = 0; k < NUM_ENTRIES; k++) q[k].valid <= 1'b0;
    end else begin
      count <= fill + CW'(acc);
      q <= q_next;
    end
  end
endmodule

// File: tb/tb_fxu_rs.sv
// tb_fxu_rs: directed and random checks of fxu_rs against a queue-based reference model
module tb_fxu_rs;
  import fxu_pkg::*;
  localparam int NE = 4;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rob;
    logic [8:0] imm;
    logic [2:0] rdy;
    logic [2:0][3:0] tag;
    logic [2:0][15:0] val;
  } ent_t;
  logic clk = 0, reset = 1;
  fxu_rs_if bus();
  fxu_rs #(.NUM_ENTRIES(NE)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  ent_t mq[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t wake(input ent_t e);
    for (int o = 0; o < 3; o++)
      if (!e.rdy[o] && bus.cdb_valid && e.tag[o] == bus.cdb_rob_index) begin
        e.rdy[o] = 1'b1;
        e.val[o] = bus.cdb_value;
      end
    return e;
  endfunction

  task automatic tick();
    int s = -1;
    ent_t e = '0;
    ent_t d = '0;
    bit acc;
    for (int i = 0; i < mq.size(); i++) if (s < 0 && &mq[i].rdy) s = i;
    if (s >= 0) e = mq[s];
    chk("disp_ready", bus.disp_ready, mq.size() < NE);
    chk("iss_valid", bus.iss_valid, s >= 0);
    chk("iss_opcode", bus.iss_opcode, e.op);
    chk("iss_rob", bus.iss_rob_index, e.rob);
    chk("iss_imm", bus.iss_imm, e.imm);
    chk("iss_vt", bus.iss_vt, e.val[0]);
    chk("iss_va", bus.iss_va, e.val[1]);
    chk("iss_vb", bus.iss_vb, e.val[2]);
    if (reset || bus.flush) mq.delete();
    else begin
      acc = bus.disp_valid && mq.size() < NE;
      d.op = bus.disp_opcode;
      d.rob = bus.disp_rob_index;
      d.imm = bus.disp_imm;
      d.rdy = {bus.disp_b_rdy, bus.disp_a_rdy, bus.disp_t_rdy};
      d.tag = {bus.disp_b_tag, bus.disp_a_tag, bus.disp_t_tag};
      d.val = {bus.disp_b_val, bus.disp_a_val, bus.disp_t_val};
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (s >= 0) mq.delete(s);
      if (acc) mq.push_back(wake(d));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.flush = 0;
    bus.disp_valid = 0;
    bus.cdb_valid = 0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [3:0] rob, input logic ar, input logic [3:0] atag,
                          input logic [15:0] aval, input logic br, input logic [3:0] btag, input logic [15:0] bval);
    bus.disp_valid = 1;
    bus.disp_opcode = op;
    bus.disp_rob_index = rob;
    bus.disp_imm = 9'(rob) + 9'd100;
    bus.disp_t_rdy = 1;
    bus.disp_t_tag = 0;
    bus.disp_t_val = 16'h00aa;
    bus.disp_a_rdy = ar;
    bus.disp_a_tag = atag;
    bus.disp_a_val = aval;
    bus.disp_b_rdy = br;
    bus.disp_b_tag = btag;
    bus.disp_b_val = bval;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] v);
    bus.cdb_valid = 1;
    bus.cdb_rob_index = tag;
    bus.cdb_value = v;
  endtask

  initial begin
    idle();
    set_disp(0, 0, 1, 0, 0, 1, 0, 0);
    bus.disp_valid = 0;
    cdb(0, 0);
    bus.cdb_valid = 0;
    @(posedge clk);
    @(negedge clk);
    tick();
    reset = 0;
    chk("reset_iss_valid", bus.iss_valid, 0);
    chk("reset_disp_ready", bus.disp_ready, 1);
    set_disp(OP_ADD, 3, 1, 0, 5, 1, 0, 7);
    tick();
    idle();
    chk("allrdy_valid", bus.iss_valid, 1);
    chk("allrdy_rob", bus.iss_rob_index, 3);
    chk("allrdy_va", bus.iss_va, 5);
    chk("allrdy_vb", bus.iss_vb, 7);
    tick();
    chk("allrdy_empty", bus.iss_valid, 0);
    set_disp(OP_SUB, 2, 0, 9, 0, 1, 0, 4);
    tick();
    idle();
    chk("wake_wait", bus.iss_valid, 0);
    cdb(9, 16'h0010);
    chk("wake_cycle_n", bus.iss_valid, 0);
    tick();
    idle();
    chk("wake_n1_valid", bus.iss_valid, 1);
    chk("wake_n1_va", bus.iss_va, 16'h0010);
    chk("wake_n1_vb", bus.iss_vb, 4);
    tick();
    set_disp(OP_MOV, 7, 0, 6, 0, 1, 0, 0);
    cdb(6, 16'hbeef);
    tick();
    idle();
    chk("samecyc_valid", bus.iss_valid, 1);
    chk("samecyc_va", bus.iss_va, 16'hbeef);
    tick();
    for (int r = 1; r <= 3; r++) begin
      set_disp(OP_ADD, 4'(r), 0, 5, 0, 1, 0, 16'(r));
      tick();
    end
    idle();
    cdb(5, 16'h0055);
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      chk("order_rob", bus.iss_rob_index, r);
      chk("order_ready", bus.disp_ready, 1);
      tick();
    end
    chk("order_done", bus.iss_valid, 0);
    for (int r = 0; r < 4; r++) begin
      set_disp(OP_MOVL, 4'(8 + r), 0, 4'(12 + r), 0, 1, 0, 16'(r));
      tick();
    end
    chk("full_ready", bus.disp_ready, 0);
    set_disp(OP_ADD, 13, 1, 0, 1, 1, 0, 2);
    tick();
    idle();
    chk("full_ignored", bus.iss_valid, 0);
    cdb(12, 16'h1234);
    tick();
    idle();
    chk("full_issue_rob", bus.iss_rob_index, 8);
    chk("full_issue_ready", bus.disp_ready, 0);
    tick();
    chk("full_freed", bus.disp_ready, 1);
    cdb(13, 16'h4321);
    tick();
    idle();
    chk("flush_issuable", bus.iss_valid, 1);
    bus.flush = 1;
    tick();
    idle();
    chk("flush_valid", bus.iss_valid, 0);
    chk("flush_ready", bus.disp_ready, 1);
    cdb(14, 1);
    tick();
    cdb(15, 2);
    tick();
    idle();
    chk("flush_stale", bus.iss_valid, 0);
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 199) == 0;
      bus.flush = $urandom_range(0, 59) == 0;
      bus.disp_valid = $urandom_range(0, 2) != 0;
      bus.disp_opcode = 4'($urandom);
      bus.disp_rob_index = 4'($urandom);
      bus.disp_imm = 9'($urandom);
      bus.disp_t_rdy = $urandom_range(0, 4) < 3;
      bus.disp_a_rdy = $urandom_range(0, 4) < 3;
      bus.disp_b_rdy = $urandom_range(0, 4) < 3;
      bus.disp_t_tag = 4'($urandom_range(0, 7));
      bus.disp_a_tag = 4'($urandom_range(0, 7));
      bus.disp_b_tag = 4'($urandom_range(0, 7));
      bus.disp_t_val = 16'($urandom);
      bus.disp_a_val = 16'($urandom);
      bus.disp_b_val = 16'($urandom);
      bus.cdb_valid = $urandom_range(0, 1) == 1;
      bus.cdb_rob_index = 4'($urandom_range(0, 8));
      bus.cdb_value = 16'($urandom);
      tick();
    end
    reset = 0;
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fxu_rs.md
Name: fxu_rs

Overview:
- Reservation station in front of the FXU, holding dispatched fixed-point instructions until all their source operands are ready.
- Snoops the result broadcast bus (FXU result / CDB) to capture pending operand values by ROB tag.
- Issues at most one instruction per cycle to the FXU, oldest-ready first.
- Sits between dispatch/rename and the FXU, and consumes the same {valid, rob_index, value} broadcast the FXU produces.

Parameters:
- NUM_ENTRIES, 4, number of station slots (2..8).
- TAG_W, 4, ROB index width.
- DATA_W, 16, register value width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept this cycle
- disp_opcode  in  4  FXU opcode
- disp_rob_index  in  TAG_W  destination ROB slot
- disp_imm  in  9  immediate i
- disp_t_rdy, disp_a_rdy, disp_b_rdy  in  1 each  operand value already known
- disp_t_tag, disp_a_tag, disp_b_tag  in  TAG_W each  producer ROB index when not ready
- disp_t_val, disp_a_val, disp_b_val  in  DATA_W each  operand value when ready
- cdb_valid  in  1  result broadcast valid
- cdb_rob_index  in  TAG_W  broadcasting producer
- cdb_value  in  DATA_W  broadcast value
- iss_valid  out  1  instruction presented to FXU
- iss_opcode  out  4
- iss_rob_index  out  TAG_W
- iss_vt, iss_va, iss_vb  out  DATA_W each
- iss_imm  out  9

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset and flush: on a clk edge with reset=1 or flush=1, all entries are invalidated and count becomes 0.
  - iss_valid is 0 from the following cycle; disp_ready is 1.
  - Reset and flush take priority over a same-cycle dispatch, issue and CDB capture.
- Storage: collapsing queue. Slot 0 is always the oldest valid entry and valid slots are contiguous from 0.
- Each entry holds: valid, opcode, rob_index, imm, and per operand (t, a, b) a rdy bit, tag and value.
- disp_ready = (count < NUM_ENTRIES), computed from registered count only.
  - No same-cycle reuse of a slot freed by issue. A full station stays not-ready during the cycle it issues.
- Dispatch accepted when disp_valid && disp_ready. The entry is written at slot count (after collapse if an issue also occurs this cycle).
- Wakeup:
  - For every valid entry and every operand with rdy=0: if cdb_valid and tag==cdb_rob_index, set rdy=1 and value=cdb_value at the edge.
  - The same match applies to the operands of an instruction being dispatched this cycle, so a dispatched operand whose producer broadcasts that cycle enters the station already ready.
- Ready entry: valid && t_rdy && a_rdy && b_rdy, evaluated on registered state only. A wakeup makes an entry issuable the cycle after the broadcast, never the same cycle.
- Issue:
  - iss_* are combinational from the lowest-index ready slot.
  - iss_valid=1 if any slot is ready.
  - The FXU always accepts, so the issued slot is removed at the same edge and higher slots shift down by one.
  - Unsupported opcodes are issued unchanged; the FXU drops them.
- Outputs when iss_valid=0: all iss_* data outputs are 0.
- Count: count_next = count + accepted_dispatch - issue. Count never exceeds NUM_ENTRIES and never underflows.
- Simultaneous events:
  - Dispatch + issue + CDB wakeup in one cycle must all take effect.
  - A CDB tag matching several entries and operands wakes all of them.
  - A CDB carrying a tag that no entry waits on has no effect.

Decomposition:
- Shared package fxu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MOV=4, OP_MOVL=5, OP_MOVH=6;
  - TAG_W and DATA_W defaults;
  - the operand struct {rdy, tag, value} and the rs-entry struct.
- One natural sub-module, rs_operand_capture: a single operand's rdy/tag/value register with CDB match and update. It is instantiated 3 × NUM_ENTRIES times, plus the dispatch-path match.

Test Plan:
- All-ready dispatch: reset, dispatch ADD rob=3 with a=5, b=7, all rdy.
  - Next cycle: iss_valid=1, iss_rob_index=3, iss_va=5, iss_vb=7.
  - Following cycle: iss_valid=0, count=0.
- Wakeup latency: dispatch SUB rob=2 with a waiting on tag 9 (b rdy=4). Cycle N: cdb_valid, index 9, value 0x0010.
  - iss_valid=0 in cycle N; iss_valid=1 in N+1 with iss_va=0x0010, iss_vb=4.
- Same-cycle dispatch/broadcast: dispatch MOV with a waiting on tag 6 while the CDB broadcasts 6/0xBEEF in that cycle.
  - Next cycle: issues with iss_va=0xBEEF.
- Oldest-first and collapse: dispatch rob 1, 2, 3 all waiting on tag 5, then broadcast tag 5.
  - Issue order is 1, 2, 3 on consecutive cycles; disp_ready stays 1 throughout.
- Full: dispatch 4 non-ready entries.
  - disp_ready=0; a fifth disp_valid is ignored.
  - After one entry wakes and issues, disp_ready=1 the cycle after removal.
- Flush mid-operation: 3 entries held, assert flush while an entry is issuable.
  - Next cycle: iss_valid=0, disp_ready=1.
  - A later CDB broadcast of the old tags causes no issue.
